scoreboard_unit: RTL and testbench

// Write-side counterpart to the compare-based stall logic: records every register write issued from ID
// and clears it at WB retire, so ID can stall on a single per-register lookup instead of per-stage compares.

---
 rtl/scoreboard_unit.sv | 71 +++++++
 tb/tb_scoreboard_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/scoreboard_unit.sv
// scoreboard_unit: per-register pending-write counters feeding the ID stall; SCOREBOARD_WB_BYPASS_EN releases stall in the WB retire cycle
module scoreboard_unit #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [$clog2(NREG)-1:0] rs_ID,
  input  logic [$clog2(NREG)-1:0] rt_ID,
  input  logic                    issue_ID,
  input  logic                    regwrite_ID,
  input  logic [$clog2(NREG)-1:0] writereg_ID,
  input  logic                    flush_EX,
  input  logic                    regwrite_EX,
  input  logic [$clog2(NREG)-1:0] writereg_EX,
  input  logic                    retire_WB,
  input  logic [$clog2(NREG)-1:0] writereg_WB,
  output logic                    stall,
  output logic                    pending_any,
  output logic                    sb_error
);
  localparam int IW = $clog2(NREG);
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0] err;
  logic sb_error_q, sb_error_d;
  logic byp_rs, byp_rt;
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    logic inc, dwb, dex, un, ov;
    logic [CNT_W:0] up, dn, res;
    always_comb begin
      inc = (r != 0) && issue_ID && !stall && regwrite_ID && writereg_ID == IW'(r);
      dwb = (r != 0) && retire_WB && writereg_WB == IW'(r);
      dex = (r != 0) && flush_EX && regwrite_EX && writereg_EX == IW'(r);
      up  = {1'b0, cnt_q[r]} + (CNT_W+1)'(inc);
      dn  = (CNT_W+1)'(dwb) + (CNT_W+1)'(dex);
      res = up - dn;
      un  = up < dn;
      ov  = !un && res > {1'b0, MAX};
    end
    assign err[r]   = un || ov;
    assign cnt_d[r] = un ? '0 : ov ? MAX : res[CNT_W-1:0];
  end
`ifdef SCOREBOARD_WB_BYPASS_EN
  assign byp_rs = retire_WB && writereg_WB == rs_ID && cnt_q[rs_ID] == CNT_W'(1) &&
                  !(flush_EX && regwrite_EX && writereg_EX == rs_ID);
  assign byp_rt = retire_WB && writereg_WB == rt_ID && cnt_q[rt_ID] == CNT_W'(1) &&
                  !(flush_EX && regwrite_EX && writereg_EX == rt_ID);
`else
  assign byp_rs = 1'b0;
  assign byp_rt = 1'b0;
`endif
  always_comb begin
    stall = (rs_ID != '0 && cnt_q[rs_ID] != '0 && !byp_rs) ||
            (rt_ID != '0 && cnt_q[rt_ID] != '0 && !byp_rt);
    pending_any = 1'b0;
    for (int i = 1; i < NREG; i++) pending_any = pending_any | (cnt_q[i] != '0);
    sb_error_d = sb_error_q | (|err);
  end
  assign sb_error = sb_error_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '{default: '0};
      sb_error_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sb_error_q <= sb_error_d;
    end
  end
endmodule

// File: tb/tb_scoreboard_unit.sv
// tb_scoreboard_unit: directed checks of scoreboard counting, stall, clamping and sticky error
module tb_scoreboard_unit;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs_ID, rt_ID, writereg_ID, writereg_EX, writereg_WB;
  logic issue_ID, regwrite_ID, flush_EX, regwrite_EX, retire_WB;
  logic stall, pending_any, sb_error;
  int checks = 0;
  int failures = 0;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  always #5 clk = ~clk;
  scoreboard_unit dut (
    .clk(clk), .reset(reset), .rs_ID(rs_ID), .rt_ID(rt_ID), .issue_ID(issue_ID),
    .regwrite_ID(regwrite_ID), .writereg_ID(writereg_ID), .flush_EX(flush_EX),
    .regwrite_EX(regwrite_EX), .writereg_EX(writereg_EX), .retire_WB(retire_WB),
    .writereg_WB(writereg_WB), .stall(stall), .pending_any(pending_any), .sb_error(sb_error)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    issue_ID = 0; regwrite_ID = 0; writereg_ID = 0;
    flush_EX = 0; regwrite_EX = 0; writereg_EX = 0;
    retire_WB = 0; writereg_WB = 0;
  endtask
  task automatic src(input logic [4:0] a, input logic [4:0] b);
    rs_ID = a; rt_ID = b; #1;
  endtask
  task automatic issue(input logic [4:0] r);
    issue_ID = 1; regwrite_ID = 1; writereg_ID = r; tick();
  endtask
  task automatic retire(input logic [4:0] r);
    retire_WB = 1; writereg_WB = r; tick();
  endtask
  initial begin
    reset = 1; rs_ID = 0; rt_ID = 0;
    issue_ID = 1; regwrite_ID = 1; writereg_ID = 5;
    flush_EX = 0; regwrite_EX = 0; writereg_EX = 0; retire_WB = 0; writereg_WB = 0;
    repeat (2) tick();
    check("rst_stall", stall, 0);
    check("rst_pending", pending_any, 0);
    check("rst_err", sb_error, 0);
    reset = 0;
    issue(5);
    src(5, 0); check("r5_stall", stall, 1);
    check("r5_pending", pending_any, 1);
    src(0, 0); check("r0_src_nostall", stall, 0);
    retire_WB = 1; writereg_WB = 5; src(5, 0);
    check("r5_retire_cycle", stall, {31'd0, !BYP});
    tick();
    check("r5_after_retire", stall, 0);
    check("r5_pending_clr", pending_any, 0);
    src(0, 0);
    issue(7); issue(7); issue(7);
    retire(7);
    src(7, 0); check("r7_cnt2", stall, 1);
    src(0, 0); retire(7);
    src(0, 7); check("r7_cnt1", stall, 1);
    src(0, 0); retire(7);
    src(7, 7); check("r7_cnt0", stall, 0);
    check("r7_pending", pending_any, 0);
    src(0, 0);
    issue(9);
    issue_ID = 1; regwrite_ID = 1; writereg_ID = 9; retire_WB = 1; writereg_WB = 9; tick();
    src(0, 9); check("r9_net0", stall, 1);
    src(0, 0); retire(9);
    src(0, 9); check("r9_drained", stall, 0);
    check("r9_err", sb_error, 0);
    src(0, 0);
    issue(3);
    flush_EX = 1; regwrite_EX = 1; writereg_EX = 3; tick();
    src(3, 0); check("r3_flushed", stall, 0);
    check("r3_pending", pending_any, 0);
    src(0, 0); issue(3);
    src(3, 0); check("r3_stall", stall, 1);
    issue(6);
    issue(3);
    src(6, 0); check("r6_not_counted", stall, 0);
    check("r6_pending", pending_any, 1);
    src(0, 0); retire(3);
    src(3, 0); check("r3_single_cnt", stall, 0);
    check("r3_pending_clr", pending_any, 0);
    src(0, 0);
    issue(8); issue(8);
    retire_WB = 1; writereg_WB = 8; flush_EX = 1; regwrite_EX = 1; writereg_EX = 8; tick();
    src(8, 0); check("r8_net_m2", stall, 0);
    check("r8_pending", pending_any, 0);
    check("r8_err", sb_error, 0);
    src(0, 0);
    issue(0);
    check("r0_issue_pending", pending_any, 0);
    retire(0);
    check("r0_retire_err", sb_error, 0);
    retire(4);
    check("r4_underflow_err", sb_error, 1);
    src(4, 0); check("r4_clamp0", stall, 0);
    check("r4_pending", pending_any, 0);
    src(0, 0);
    reset = 1; tick(); reset = 0;
    check("reset_clears_err", sb_error, 0);
    issue(4); issue(4); issue(4);
    check("r4_max_noerr", sb_error, 0);
    issue(4);
    check("r4_overflow_err", sb_error, 1);
    retire(4); retire(4);
    src(4, 0); check("r4_cnt1", stall, 1);
    src(0, 0); retire(4);
    src(4, 0); check("r4_held_max", stall, 0);
    check("r4_pending_clr", pending_any, 0);
    check("err_sticky", sb_error, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
